alu_pipelined_muldiv: RTL and testbench

// - Parametrised successor ALU for the datapath: WIDTH-bit operands, 4-bit function code, registered result.
// - Single-cycle logic/arith ops plus iterative multiply/divide, behind a valid/ready handshake on both sides.
// - Sits between operand fetch and writeback; the controller stalls on in_ready=0.

---
 rtl/alu_pipelined_muldiv.sv | 208 ++++++++++++++++++++
 tb/tb_alu_pipelined_muldiv.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipelined_muldiv.sv
// Pipelined ALU: single-cycle logic/arith ops with a registered result, plus iterative MUL/DIVU/REMU.
// Build option ALU_MULDIV_EN enables the multiply/divide FSM; without it op codes 1001-1011 are illegal.
module alu_pipelined_muldiv #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [3:0]       alu_function,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_output,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal_op
);
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1100;
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
`endif

  // Handshake: an op transfers on a rising edge with in_valid & in_ready; a result transfers on a
  // rising edge with out_valid & out_ready, and stays stable while out_valid & ~out_ready.
  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sc_result;
  logic               sc_illegal;

  assign accept = in_valid && in_ready;
  assign shamt  = input_b[SHAMT_W-1:0];

`ifdef ALU_MULDIV_EN
  logic sc_dbz;
  logic start_iter;
`endif

  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
`ifdef ALU_MULDIV_EN
    sc_dbz     = 1'b0;
    start_iter = 1'b0;
`endif
    case (alu_function)
      OP_ADD:  sc_result = input_a + input_b;
      OP_SUB:  sc_result = input_a - input_b;
      OP_AND:  sc_result = input_a & input_b;
      OP_OR:   sc_result = input_a | input_b;
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, input_a < input_b};
      OP_XOR:  sc_result = input_a ^ input_b;
      OP_SLL:  sc_result = input_a << shamt;
      OP_SRL:  sc_result = input_a >> shamt;
      OP_SRA:  sc_result = $signed(input_a) >>> shamt;
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(input_a) < $signed(input_b)};
`ifdef ALU_MULDIV_EN
      OP_MUL:  start_iter = 1'b1;
      // Divide by zero bypasses the iteration: quotient all-ones, remainder is the dividend.
      OP_DIVU, OP_REMU: begin
        if (input_b == '0) begin
          sc_dbz    = 1'b1;
          sc_result = alu_function[0] ? input_a : '1;
        end else begin
          start_iter = 1'b1;
        end
      end
`endif
      default: sc_illegal = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t             state;
  logic [SHAMT_W-1:0] cnt;
  // MUL: acc_q=accumulator, opnd_q=shifting multiplicand, bits_q=multiplier.
  // DIV: acc_q=partial remainder, opnd_q=divisor, bits_q=dividend shifting into quotient.
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   bits_q;
  logic               is_rem;
  logic [WIDTH-1:0]   mul_acc;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_res;
  logic               last;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign mul_acc   = bits_q[0] ? acc_q + opnd_q : acc_q;
  assign div_shift = {acc_q, bits_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ok    = !div_diff[WIDTH];
  assign div_rem   = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quo   = {bits_q[WIDTH-2:0], div_ok};
  assign div_res   = is_rem ? div_rem : div_quo;
  assign last      = (cnt == SHAMT_W'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      bits_q      <= '0;
      is_rem      <= 1'b0;
      out_valid   <= 1'b0;
      alu_output  <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (start_iter) begin
              cnt    <= '0;
              acc_q  <= '0;
              is_rem <= alu_function[0];
              if (alu_function == OP_MUL) begin
                state  <= MUL;
                opnd_q <= input_a;
                bits_q <= input_b;
              end else begin
                state  <= DIV;
                opnd_q <= input_b;
                bits_q <= input_a;
              end
            end else begin
              out_valid   <= 1'b1;
              alu_output  <= sc_result;
              zero        <= (sc_result == '0);
              div_by_zero <= sc_dbz;
              illegal_op  <= sc_illegal;
            end
          end
        end
        MUL: begin
          acc_q  <= mul_acc;
          opnd_q <= opnd_q << 1;
          bits_q <= bits_q >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            state       <= IDLE;
            out_valid   <= 1'b1;
            alu_output  <= mul_acc;
            zero        <= (mul_acc == '0);
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
          end
        end
        DIV: begin
          acc_q  <= div_rem;
          bits_q <= div_quo;
          cnt    <= cnt + 1'b1;
          if (last) begin
            state       <= IDLE;
            out_valid   <= 1'b1;
            alu_output  <= div_res;
            zero        <= (div_res == '0);
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign in_ready    = !out_valid || out_ready;
  assign div_by_zero = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      alu_output <= '0;
      zero       <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        out_valid  <= 1'b1;
        alu_output <= sc_result;
        zero       <= (sc_result == '0);
        illegal_op <= sc_illegal;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipelined_muldiv.sv
// Self-checking bench for alu_pipelined_muldiv: directed steps plus a scoreboard queue of expected results.
// Expected results are packed as {alu_output, zero, div_by_zero, illegal_op}.
module tb_alu_pipelined_muldiv;
  localparam int W  = 32;
  localparam int EW = W + 3;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1100;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] input_a;
  logic [W-1:0] input_b;
  logic [3:0]   alu_function;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_output;
  logic         zero;
  logic         div_by_zero;
  logic         illegal_op;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  alu_pipelined_muldiv #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .input_a(input_a), .input_b(input_b), .alu_function(alu_function),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_output(alu_output), .zero(zero),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $error("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  function automatic logic [EW-1:0] pk(input logic [W-1:0] r, input logic z, input logic d,
                                       input logic i);
    return {r, z, d, i};
  endfunction

  // Reference model of one operation
  function automatic logic [EW-1:0] model(input logic [3:0] fn, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         dbz;
    logic         ill;
    int           sh;
    r   = '0;
    dbz = 1'b0;
    ill = 1'b0;
    sh  = int'(b[4:0]);
    case (fn)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLTU: r = (a < b) ? 1 : 0;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $signed(a) >>> sh;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 1 : 0;
`ifdef ALU_MULDIV_EN
      OP_MUL:  r = a * b;
      OP_DIVU: if (b == 0) begin r = '1; dbz = 1'b1; end else r = a / b;
      OP_REMU: if (b == 0) begin r = a;  dbz = 1'b1; end else r = a % b;
`endif
      default: ill = 1'b1;
    endcase
    return pk(r, (r == '0), dbz, ill);
  endfunction

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: present an op at a negedge, wait (bounded) for in_ready, push the expectation,
  // then drop in_valid and scramble the inputs after the accept edge.
  task automatic issue(input logic [3:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [EW-1:0] exp, output int waited);
    in_valid     = 1'b1;
    alu_function = fn;
    input_a      = a;
    input_b      = b;
    waited       = 0;
    #1;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      out_ready = 1'b1;
      waited++;
      #1;
    end
    chk("issue_ready", in_ready, 1);
    if (in_ready) exp_q.push_back(exp);
    @(negedge clk);
    in_valid     = 1'b0;
    alu_function = 4'($urandom_range(0, 15));
    input_a      = $urandom();
    input_b      = $urandom();
  endtask

  // Scoreboard: pop and compare on every output handshake
  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $error("FAIL unexpected_output: observed %h expected none",
               {alu_output, zero, div_by_zero, illegal_op});
      end else begin
        chk("result", {alu_output, zero, div_by_zero, illegal_op}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int           waited;
    int           n;
    logic [3:0]   fn;
    logic [W-1:0] a;
    logic [W-1:0] b;

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    alu_function = '0;
    input_a      = '0;
    input_b      = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_output", alu_output, 0);
    chk("rst_zero", zero, 0);
    chk("rst_div_by_zero", div_by_zero, 0);
    chk("rst_illegal_op", illegal_op, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, pk(32'h0, 1, 0, 0), waited);
    chk("add_latency", out_valid, 1);
    chk("add_zero", zero, 1);
    issue(OP_SUB, 32'd5, 32'd7, pk(32'hFFFF_FFFE, 0, 0, 0), waited);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1, pk(32'h0, 1, 0, 0), waited);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'h1, pk(32'h1, 0, 0, 0), waited);
    issue(OP_SRA, 32'h8000_0000, 32'h21, pk(32'hC000_0000, 0, 0, 0), waited);
    issue(OP_SLL, 32'h1, 32'h3F, pk(32'h8000_0000, 0, 0, 0), waited);
    issue(OP_SRL, 32'h8000_0000, 32'h1F, pk(32'h1, 0, 0, 0), waited);
    issue(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, pk(32'hF0F0_0F0F, 0, 0, 0), waited);
    issue(OP_XOR, 32'h1234_5678, 32'h1234_5678, pk(32'h0, 1, 0, 0), waited);
    issue(4'b1111, 32'h5, 32'h6, pk(32'h0, 1, 0, 1), waited);
    issue(OP_ADD, 32'h10, 32'h20, pk(32'h30, 0, 0, 0), waited);
    chk("flags_cleared", illegal_op, 0);

`ifdef ALU_MULDIV_EN
    issue(OP_MUL, 32'd7, 32'd6, pk(32'd42, 0, 0, 0), waited);
    for (int i = 0; i < 32; i++) begin
      chk("mul_busy", {in_ready, out_valid}, 2'b00);
      @(negedge clk);
    end
    chk("mul_done", out_valid, 1);
    issue(OP_MUL, 32'h1_0000, 32'h1_0000, pk(32'h0, 1, 0, 0), waited);
    issue(OP_DIVU, 32'd100, 32'd7, pk(32'd14, 0, 0, 0), waited);
    issue(OP_REMU, 32'd100, 32'd7, pk(32'd2, 0, 0, 0), waited);
    issue(OP_DIVU, 32'd9, 32'd0, pk(32'hFFFF_FFFF, 0, 1, 0), waited);
    chk("dbz_latency", out_valid, 1);
    issue(OP_REMU, 32'd9, 32'd0, pk(32'd9, 0, 1, 0), waited);
    issue(OP_ADD, 32'd1, 32'd1, pk(32'd2, 0, 0, 0), waited);
    chk("dbz_cleared", div_by_zero, 0);
`else
    issue(OP_MUL, 32'd7, 32'd6, pk(32'h0, 1, 0, 1), waited);
    chk("mul_illegal_latency", out_valid, 1);
    issue(OP_DIVU, 32'd9, 32'd0, pk(32'h0, 1, 0, 1), waited);
    chk("divu_illegal_dbz", div_by_zero, 0);
`endif

    // Backpressure: hold an AND result for 5 cycles, then accept a new op as out_ready rises
    issue(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, pk(32'h0F00_0F00, 0, 0, 0), waited);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", {alu_output, zero, out_valid}, {32'h0F00_0F00, 1'b0, 1'b1});
    end
    out_ready = 1'b1;
    issue(OP_SUB, 32'd10, 32'd3, pk(32'd7, 0, 0, 0), waited);
    chk("bp_same_cycle", waited, 0);

    // Reset mid-operation: nothing emitted, outputs cleared at once
`ifdef ALU_MULDIV_EN
    issue(OP_DIVU, 32'd1000, 32'd3, pk(32'd333, 0, 0, 0), waited);
    repeat (9) @(negedge clk);
`else
    issue(OP_XOR, 32'h0, 32'h55, pk(32'h55, 0, 0, 0), waited);
    out_ready = 1'b0;
    @(negedge clk);
`endif
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_outputs", {out_valid, alu_output, zero, div_by_zero, illegal_op}, '0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    issue(OP_ADD, 32'd2, 32'd3, pk(32'd5, 0, 0, 0), waited);
    chk("post_rst_latency", out_valid, 1);

    // Random ops with random consumer stalls
    for (int i = 0; i < 40; i++) begin
      fn        = 4'($urandom_range(0, 15));
      a         = $urandom();
      b         = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      issue(fn, a, b, model(fn, a, b), waited);
    end

    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    #2;
    chk("drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
